// File: rtl/input_debouncer.sv
// Per-line switch/sensor debouncer: synchronizer, persistence counter, change pulse, startup valid.
// Optional macro INPUT_DEBOUNCER_SYNC2_EN selects a two-flop synchronizer (default: single capture flop).

module input_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = 3
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_raw,
  output logic o_x,
  output logic o_upd
);

  logic          w_s;
  logic          w_diff;
  logic          r_x;
  logic [CW-1:0] r_cnt;

`ifdef INPUT_DEBOUNCER_SYNC2_EN
  logic [1:0] r_sync;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_sync <= '0;
    else         r_sync <= {r_sync[0], i_raw};
  end
  assign w_s = r_sync[1];
`else
  logic r_sync;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_sync <= 1'b0;
    else         r_sync <= i_raw;
  end
  assign w_s = r_sync;
`endif

  assign w_diff = w_s ^ r_x;
  assign o_upd  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Any sample agreeing with x restarts qualification, so a glitch never moves x.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_x   <= 1'b0;
      r_cnt <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (o_upd) begin
      r_x   <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_x = r_x;

endmodule

module input_debouncer #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] raw,
  output logic [N-1:0] x,
  output logic         x_chg,
  output logic         x_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N-1:0]  w_x;
  logic [N-1:0]  w_upd;
  logic          r_chg;
  logic          r_valid;
  logic [CW-1:0] r_start;

  for (genvar i = 0; i < N; i++) begin : g_lane
    input_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW)
    ) u_lane (
      .Clock (Clock),
      .Resetn(Resetn),
      .i_raw (raw[i]),
      .o_x   (w_x[i]),
      .o_upd (w_upd[i])
    );
  end

  // Simultaneous lane updates collapse into one pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_chg <= 1'b0;
    else         r_chg <= |w_upd;
  end

  // Valid rises on the DEBOUNCE_CYCLES-th edge after reset release, then sticks.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_start <= '0;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      if (r_start == CW'(DEBOUNCE_CYCLES - 1)) r_valid <= 1'b1;
      else                                      r_start <= r_start + 1'b1;
    end
  end

  assign x       = w_x;
  assign x_chg   = r_chg;
  assign x_valid = r_valid;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: vector table, hand corner sequences, randomized run vs a history-window model.
module tb_input_debouncer;

  localparam int N = 3;
  localparam int D = 4;
`ifdef INPUT_DEBOUNCER_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int LAT = D + L - 1;

  logic         Clock  = 1'b0;
  logic         Resetn = 1'b0;
  logic [N-1:0] raw    = '0;
  logic [N-1:0] x;
  logic         x_chg;
  logic         x_valid;

  always #5 Clock = ~Clock;

  input_debouncer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .raw    (raw),
    .x      (x),
    .x_chg  (x_chg),
    .x_valid(x_valid)
  );

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] ex;
    logic         chg;
    logic         vld;
  } vec_t;

  vec_t         tbl[$];
  int           n_checks = 0;
  int           n_err    = 0;
  logic [N-1:0] hist[$];
  logic [N-1:0] m_x   = '0;
  logic         m_chg = 1'b0;
  int           m_edges = 0;

  // s seen on edge m is raw captured L edges earlier; before reset release it is 0.
  function automatic logic [N-1:0] s_at(int m);
    if (m - L < 0) return '0;
    return hist[m - L];
  endfunction

  // x flips once the last D edges all presented the opposite level.
  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] nx;
    logic [N-1:0] v;
    int k;
    bit all;
    hist.push_back(r);
    k  = hist.size() - 1;
    nx = m_x;
    for (int b = 0; b < N; b++) begin
      all = 1'b1;
      for (int m = k - D + 1; m <= k; m++) begin
        if (m < 0) all = 1'b0;
        else begin
          v = s_at(m);
          if (v[b] == m_x[b]) all = 1'b0;
        end
      end
      if (all) nx[b] = ~m_x[b];
    end
    m_chg = (nx != m_x);
    m_x   = nx;
    m_edges++;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input logic [N-1:0] r);
    raw = r;
    @(posedge Clock);
    model_edge(r);
    #1;
    chk("model_x", 8'(x), 8'(m_x));
    chk("model_chg", 8'(x_chg), 8'(m_chg));
    chk("model_valid", 8'(x_valid), 8'(m_edges >= D));
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    Resetn = 1'b0;
    raw    = r;
    #1;
    chk("rst_async_x", 8'(x), 8'h0);
    chk("rst_async_chg", 8'(x_chg), 8'h0);
    chk("rst_async_valid", 8'(x_valid), 8'h0);
    repeat (3) begin
      @(posedge Clock);
      #1;
      chk("rst_hold_x", 8'(x), 8'h0);
      chk("rst_hold_chg", 8'(x_chg), 8'h0);
      chk("rst_hold_valid", 8'(x_valid), 8'h0);
    end
    #2;
    Resetn = 1'b1;
    hist.delete();
    m_x = '0; m_chg = 1'b0; m_edges = 0;
  endtask

  task automatic add_vec(input logic [N-1:0] r, input logic [N-1:0] e, input logic c, input logic v);
    vec_t t;
    t.raw = r; t.ex = e; t.chg = c; t.vld = v;
    tbl.push_back(t);
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] ex;

    // Startup valid, clean 000->011 step, then a 3-cycle glitch on bit 2.
    for (int i = 0; i < 4; i++)   add_vec(3'b000, 3'b000, 1'b0, i == D - 1);
    for (int i = 0; i < 10; i++)  add_vec(3'b011, (i >= LAT) ? 3'b011 : 3'b000, i == LAT, 1'b1);
    for (int i = 0; i < 3; i++)   add_vec(3'b111, 3'b011, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)   add_vec(3'b011, 3'b011, 1'b0, 1'b1);

    // Reset held with raw=111 while clocking.
    raw = 3'b111;
    repeat (3) begin
      @(posedge Clock);
      #1;
      chk("init_rst_x", 8'(x), 8'h0);
      chk("init_rst_chg", 8'(x_chg), 8'h0);
      chk("init_rst_valid", 8'(x_valid), 8'h0);
    end
    #2;
    Resetn = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].raw);
      chk("tbl_x", 8'(x), 8'(tbl[i].ex));
      chk("tbl_chg", 8'(x_chg), 8'(tbl[i].chg));
      chk("tbl_valid", 8'(x_valid), 8'(tbl[i].vld));
    end

    // Staggered bits: two separate updates and two separate pulses.
    repeat (LAT + 2) tick(3'b000);
    chk("stag_base", 8'(x), 8'h0);
    for (int i = 0; i <= LAT + 4; i++) begin
      tick((i < 2) ? 3'b001 : 3'b011);
      ex = (i >= LAT + 2) ? 3'b011 : (i >= LAT) ? 3'b001 : 3'b000;
      chk("stag_x", 8'(x), 8'(ex));
      chk("stag_chg", 8'(x_chg), 8'(i == LAT || i == LAT + 2));
    end

    // Reset mid-qualification discards the pending change; full latency again after release.
    repeat (3) tick(3'b100);
    chk("pend_x", 8'(x), 8'(3'b011));
    do_reset(3'b100);
    for (int i = 0; i <= LAT + 2; i++) begin
      tick(3'b100);
      chk("rst_requal_x", 8'(x), 8'((i >= LAT) ? 3'b100 : 3'b000));
      chk("rst_requal_chg", 8'(x_chg), 8'(i == LAT));
    end

    // Randomized run: mostly-stable lines with occasional flips and glitches.
    cur = 3'b100;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) cur = 3'($urandom);
      tick(cur);
      if (i % 200 == 150) do_reset(3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
